// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: shared encodings for the two-master system bus arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: owner encoding (OWN_NONE/OWN_IF/OWN_MEM) and bus data_size codes.
package bus_arbiter_pkg;

  // Who currently holds, or is being forwarded, the system bus.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_t;

  // One-hot transfer size codes on bus_data_size / mem_data_size.
  localparam logic [2:0] SIZE_BYTE = 3'b001;
  localparam logic [2:0] SIZE_HALF = 3'b010;
  localparam logic [2:0] SIZE_WORD = 3'b100;

  // Width of the fetch starvation counter; STARVE_MAX must fit (1..15).
  localparam int STARVE_W = 4;

  // True for the three legal size codes.
  function automatic logic size_valid(input logic [2:0] sz);
    return (sz == SIZE_BYTE) || (sz == SIZE_HALF) || (sz == SIZE_WORD);
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: fetch port, memory-stage port and system bus signals.
// Latency: n/a (wiring only).
// Backpressure: rw_wait level stalls toward each master, bus_rw_wait from memory.
// Modports: slave = arbiter view, master = view of the requesters plus memory.
interface bus_arbiter_if;

  // Instruction fetch port (read-only)
  logic [31:0] if_addr;
  logic        if_rd_req;
  logic        if_rw_wait;
  logic [31:0] if_rd_data;

  // Memory-stage load/store/swap port
  logic [31:0] mem_busaddr;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_wr_data;
  logic [2:0]  mem_data_size;
  logic        mem_lock;
  logic        mem_rw_wait;
  logic [31:0] mem_rd_data;

  // System memory bus
  logic [31:0] bus_addr;
  logic        bus_rd_req;
  logic        bus_wr_req;
  logic [31:0] bus_wr_data;
  logic [2:0]  bus_data_size;
  logic        bus_rw_wait;
  logic [31:0] bus_rd_data;

  // Status
  logic        grant_mem;

  modport slave (
    input  if_addr, if_rd_req,
    output if_rw_wait, if_rd_data,
    input  mem_busaddr, mem_rd_req, mem_wr_req, mem_wr_data, mem_data_size, mem_lock,
    output mem_rw_wait, mem_rd_data,
    output bus_addr, bus_rd_req, bus_wr_req, bus_wr_data, bus_data_size,
    input  bus_rw_wait, bus_rd_data,
    output grant_mem
  );

  modport master (
    output if_addr, if_rd_req,
    input  if_rw_wait, if_rd_data,
    output mem_busaddr, mem_rd_req, mem_wr_req, mem_wr_data, mem_data_size, mem_lock,
    input  mem_rw_wait, mem_rd_data,
    input  bus_addr, bus_rd_req, bus_wr_req, bus_wr_data, bus_data_size,
    output bus_rw_wait, bus_rd_data,
    input  grant_mem
  );

endinterface

// File: rtl/bus_arb_mux.sv
// bus_arb_mux: forwards the selected master's addr/req/wr_data/size to the bus.
// Latency: purely combinational, zero cycles.
// Backpressure: none here; stalls are generated by bus_arbiter.
// Ports: sel (owner_t), fetch request fields, memory-stage request fields, bus_* outputs.
module bus_arb_mux
  import bus_arbiter_pkg::*;
(
  input  owner_t      sel,
  input  logic [31:0] if_addr,
  input  logic        if_rd_req,
  input  logic [31:0] mem_addr,
  input  logic        mem_rd_req,
  input  logic        mem_wr_req,
  input  logic [31:0] mem_wr_data,
  input  logic [2:0]  mem_size,
  output logic [31:0] bus_addr,
  output logic        bus_rd_req,
  output logic        bus_wr_req,
  output logic [31:0] bus_wr_data,
  output logic [2:0]  bus_data_size
);

  always_comb begin
    // Requests default low; addr/data are don't-care when nobody is selected.
    bus_addr      = if_addr;
    bus_rd_req    = 1'b0;
    bus_wr_req    = 1'b0;
    bus_wr_data   = mem_wr_data;
    bus_data_size = SIZE_WORD;
    case (sel)
      OWN_IF: begin
        bus_addr   = if_addr;
        bus_rd_req = if_rd_req;
      end
      OWN_MEM: begin
        // rd and wr both high is illegal upstream; pass both through unchanged.
        bus_addr      = mem_addr;
        bus_rd_req    = mem_rd_req;
        bus_wr_req    = mem_wr_req;
        bus_data_size = mem_size;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master (fetch / memory stage) arbiter for the system memory bus.
// Latency: zero-cycle combinational grant from idle; ownership held across bus wait states.
// Backpressure: loser and idle masters see rw_wait=1; owner sees bus_rw_wait.
// Ports: clk, rst (async, active-high), bus (bus_arbiter_if.slave).
// Optional: define ARB_LOCK_EN to honour mem_lock (SWP pairs, LDM/STM bursts).
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = 4  // MEM completions fetch may lose before it is forced in (1..15)
)
(
  input  logic          clk,
  input  logic          rst,
  bus_arbiter_if.slave  bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  owner_t              owner, owner_nxt;
  owner_t              fwd;        // master forwarded to the bus this cycle
  logic [STARVE_W-1:0] starve_cnt, starve_nxt;
  logic                lock_hold, lock_nxt;
  logic                mem_req, fwd_req, done_if, done_mem, starved;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner      <= OWN_NONE;
      starve_cnt <= '0;
      lock_hold  <= 1'b0;
    end else begin
      owner      <= owner_nxt;
      starve_cnt <= starve_nxt;
      lock_hold  <= lock_nxt;
    end
  end

  always_comb begin
    mem_req = bus.mem_rd_req | bus.mem_wr_req;
    starved = (starve_cnt == STARVE_LIM);

    // Selection: an established owner keeps the bus; from idle MEM wins
    // unless fetch has been starved; an active lock shuts fetch out.
    fwd = owner;
    if (rst) begin
      fwd = OWN_NONE;
    end else if (owner == OWN_NONE) begin
      if (lock_hold)
        fwd = mem_req ? OWN_MEM : OWN_NONE;
      else if (mem_req && !(bus.if_rd_req && starved))
        fwd = OWN_MEM;
      else if (bus.if_rd_req)
        fwd = OWN_IF;
      else
        fwd = OWN_NONE;
    end

    fwd_req  = (fwd == OWN_IF)  ? bus.if_rd_req :
               (fwd == OWN_MEM) ? mem_req : 1'b0;
    done_if  = (fwd == OWN_IF)  && bus.if_rd_req && !bus.bus_rw_wait;
    done_mem = (fwd == OWN_MEM) && mem_req && !bus.bus_rw_wait;

    // Ownership only persists while the forwarded request is stalled; both a
    // completion and a dropped request (flush) release the bus at this edge.
    owner_nxt = (fwd_req && bus.bus_rw_wait) ? fwd : OWN_NONE;

    starve_nxt = starve_cnt;
    if (!bus.if_rd_req || done_if)
      starve_nxt = '0;
    else if (done_mem && !starved)
      starve_nxt = starve_cnt + 1'b1;

`ifdef ARB_LOCK_EN
    lock_nxt = lock_hold;
    if (done_mem)
      lock_nxt = bus.mem_lock;
    else if (!mem_req && !bus.mem_lock)
      lock_nxt = 1'b0;
`else
    lock_nxt = 1'b0;
`endif
  end

`ifndef ARB_LOCK_EN
  logic unused_lock;
  assign unused_lock = bus.mem_lock;
`endif

  bus_arb_mux u_mux (
    .sel           (fwd),
    .if_addr       (bus.if_addr),
    .if_rd_req     (bus.if_rd_req),
    .mem_addr      (bus.mem_busaddr),
    .mem_rd_req    (bus.mem_rd_req),
    .mem_wr_req    (bus.mem_wr_req),
    .mem_wr_data   (bus.mem_wr_data),
    .mem_size      (bus.mem_data_size),
    .bus_addr      (bus.bus_addr),
    .bus_rd_req    (bus.bus_rd_req),
    .bus_wr_req    (bus.bus_wr_req),
    .bus_wr_data   (bus.bus_wr_data),
    .bus_data_size (bus.bus_data_size)
  );

  assign bus.if_rw_wait  = !((fwd == OWN_IF)  && !bus.bus_rw_wait);
  assign bus.mem_rw_wait = !((fwd == OWN_MEM) && !bus.bus_rw_wait);
  assign bus.grant_mem   = (fwd == OWN_MEM);
  assign bus.if_rd_data  = bus.bus_rd_data;
  assign bus.mem_rd_data = bus.bus_rd_data;

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter in front of the single system memory bus.
- Shares the bus between the instruction-fetch port (read-only) and the memory stage's load/store/swap port.
- Picks one owner, forwards the owner's request combinationally and holds ownership across bus wait states.
- Returns wait to the losing master and guards fetch against starvation.

Parameters:
STARVE_MAX, 4, back-to-back memory-stage completions allowed while fetch waits before fetch is forced to win (1..15)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
if_addr  in  32  fetch address
if_rd_req  in  1  fetch read request
if_rw_wait  out  1  fetch stall; 1 unless fetch owns the bus and bus_rw_wait=0
if_rd_data  out  32  read data to fetch (bus_rd_data broadcast)
mem_busaddr  in  32  memory-stage address
mem_rd_req  in  1  memory-stage read request
mem_wr_req  in  1  memory-stage write request
mem_wr_data  in  32  memory-stage write data
mem_data_size  in  3  size code: 001 byte, 010 half, 100 word
mem_lock  in  1  hold bus after current transaction (used only with ARB_LOCK_EN)
mem_rw_wait  out  1  memory-stage stall; same rule as if_rw_wait
mem_rd_data  out  32  read data to memory stage (bus_rd_data broadcast)
bus_addr  out  32  to memory
bus_rd_req  out  1  to memory
bus_wr_req  out  1  to memory
bus_wr_data  out  32  to memory
bus_data_size  out  3  to memory; fetch always drives 100
bus_rw_wait  in  1  memory not done
grant_mem  out  1  1 when the memory stage is the current/forwarded owner (status)

Behaviour:
- Requests are level. A transaction completes in the cycle its owner's request is high and bus_rw_wait=0.
- Registered state:
  - owner: NONE/IF/MEM.
  - starve_cnt: 4 bits.
  - lock_hold: 1 bit.
- Reset (async, while rst=1):
  - owner=NONE, starve_cnt=0, lock_hold=0.
  - Outputs forced: bus_rd_req=0, bus_wr_req=0, if_rw_wait=1, mem_rw_wait=1, grant_mem=0.
  - Data/addr outputs are don't-care.
- owner=NONE, arbitration is combinational, in the same cycle, with zero added latency:
  - Only one master requesting: that master is selected.
  - Both requesting: MEM wins, except when starve_cnt==STARVE_MAX, then IF wins.
  - Selected master's signals go to bus_*. Its rw_wait equals bus_rw_wait. The loser sees rw_wait=1.
  - If bus_rw_wait=1, owner registers the selected master at the clock edge.
- owner=IF or MEM:
  - Only the owner is forwarded; the other master sees rw_wait=1.
  - Owner returns to NONE on the completion edge.
  - If the owner drops its request mid-transaction (flush), bus_* requests go 0 that cycle and owner returns to NONE at the next edge. The other master is not granted in the abandon cycle.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on each MEM completion while if_rd_req=1.
  - Clears on IF completion, and on any edge with if_rd_req=0.
- No master requesting: bus requests 0, grant_mem=0, both rw_wait=1.
- mem_rd_req and mem_wr_req both high is illegal; forward both unchanged. The bench flags it.

Optional Feature:
- Macro ARB_LOCK_EN, for atomic SWP read/write pairs and LDM/STM bursts.
- Defined:
  - A MEM completion with mem_lock=1 sets lock_hold.
  - While lock_hold=1, IF is never selected, including over a starvation override, and MEM is selected as soon as it requests.
  - lock_hold clears on a MEM completion with mem_lock=0, or on any edge where mem_rd_req=mem_wr_req=0 and mem_lock=0.
- Undefined: mem_lock is ignored and lock_hold is constant 0.

Decomposition:
- Shared package: owner encoding (OWN_NONE, OWN_IF, OWN_MEM) and data_size codes (SIZE_BYTE=001, SIZE_HALF=010, SIZE_WORD=100), next to the existing ARM constants include.
- One natural sub-module: bus_arb_mux, a pure combinational 2:1 forwarder of addr/req/wr_data/size selected by the owner.
- Arbitration state, counter and lock stay in bus_arbiter.

Test Plan:
- Fetch alone, if_addr=0x100, bus_rw_wait=0 → bus_addr=0x100, bus_data_size=100, if_rw_wait=0 in the same cycle, grant_mem=0.
- Both request from idle, bus_rw_wait 1,1,0 → MEM owns for 3 cycles, if_rw_wait=1 throughout, IF forwarded in the cycle after MEM completes.
- STARVE_MAX=4, MEM completes back-to-back with fetch requesting → 5th arbitration grants IF, starve_cnt=0 after IF completes.
- MEM owner with bus_rw_wait=1 drops mem_wr_req (flush) → bus_wr_req=0 that cycle, owner=NONE next edge, IF granted the cycle after.
- rst pulsed mid-transaction with owner=MEM → bus_rd_req/bus_wr_req=0 immediately, both rw_wait=1, owner=NONE after release.
- ARB_LOCK_EN: SWP read with mem_lock=1, then write with mem_lock=0, fetch requesting throughout → IF granted only after the write completes.
